// File: rtl/opb_register_simulink2ppc_if.sv
// OPB slave-side bus bundle for the Simulink-to-PPC register block.
// Big-endian bit numbering (bit 0 = MSB) as on the OPB.
interface opb_register_simulink2ppc_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [0:AW-1] OPB_ABus;
  logic [0:3]    OPB_BE;
  logic [0:DW-1] OPB_DBus;
  logic          OPB_RNW;
  logic          OPB_select;
  logic          OPB_seqAddr;
  logic [0:DW-1] Sl_DBus;
  logic          Sl_xferAck;
  logic          Sl_errAck;
  logic          Sl_retry;
  logic          Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc.sv
// OPB register window exposing a fabric-captured word (DATA), NEW/OVF status
// and an optional capture counter (enabled by macro SIMULINK2PPC_COUNT_EN).
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01110000,
  parameter logic [31:0] C_HIGHADDR   = 32'h011100FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  opb_register_simulink2ppc_if.slave        opb,
  input  logic [31:0]                       user_data_in,
  input  logic                              user_valid
);
  localparam int AW = C_OPB_AWIDTH;
  localparam int DW = C_OPB_DWIDTH;

  typedef enum logic {IDLE, ACK} state_t;
  typedef enum logic [1:0] {SEL_DATA, SEL_STATUS, SEL_COUNT, SEL_NONE} sel_t;
  typedef struct packed {
    logic rnw;
    sel_t sel;
    logic ovf_clr;
  } req_t;

  state_t        r_state;
  req_t          r_req;
  logic          r_ack;
  logic [DW-1:0] r_dbus;
  logic [31:0]   r_data;
  logic          r_new;
  logic          r_ovf;

  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_off;
  logic          w_hit;
  sel_t          w_sel;
  logic [31:0]   w_count;
  logic [DW-1:0] w_rdata;
  logic          w_in_ack;
  logic          w_rd_data;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_unused;

  assign w_addr = opb.OPB_ABus;
  assign w_off  = w_addr - AW'(C_BASEADDR);
  assign w_hit  = opb.OPB_select && (w_addr >= AW'(C_BASEADDR)) && (w_addr <= AW'(C_HIGHADDR));

  always_comb begin
    w_sel = SEL_NONE;
    if (w_off == AW'(0))      w_sel = SEL_DATA;
    else if (w_off == AW'(4)) w_sel = SEL_STATUS;
    else if (w_off == AW'(8)) w_sel = SEL_COUNT;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_DATA:   w_rdata = DW'(r_data);
      SEL_STATUS: w_rdata = DW'({r_ovf, r_new});
      SEL_COUNT:  w_rdata = DW'(w_count);
      default:    w_rdata = '0;
    endcase
  end

  // Side effects of a transfer land in its ACK cycle, from the request latched at the hit.
  assign w_in_ack  = (r_state == ACK);
  assign w_rd_data = w_in_ack && r_req.rnw && (r_req.sel == SEL_DATA);
  assign w_ovf_clr = w_in_ack && !r_req.rnw && (r_req.sel == SEL_STATUS) && r_req.ovf_clr;
  assign w_ovf_set = user_valid && r_new && !w_rd_data;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_ack   <= 1'b0;
      r_dbus  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hit) begin
          r_state     <= ACK;
          r_ack       <= 1'b1;
          r_dbus      <= opb.OPB_RNW ? w_rdata : '0;
          r_req.rnw     <= opb.OPB_RNW;
          r_req.sel     <= w_sel;
          r_req.ovf_clr <= opb.OPB_DBus[30];
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_dbus  <= '0;
        end
      endcase
    end
  end

  // A capture always beats a concurrent DATA-read clear, and an OVF set beats a W1C.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_data <= '0;
      r_new  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (user_valid)     r_data <= user_data_in;
      if (user_valid)     r_new  <= 1'b1;
      else if (w_rd_data) r_new  <= 1'b0;
      if (w_ovf_set)      r_ovf  <= 1'b1;
      else if (w_ovf_clr) r_ovf  <= 1'b0;
    end
  end

`ifdef SIMULINK2PPC_COUNT_EN
  logic [31:0] r_count;
  logic        w_cnt_clr;

  assign w_cnt_clr = w_in_ack && !r_req.rnw && (r_req.sel == SEL_COUNT);

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)      r_count <= '0;
    else if (w_cnt_clr)  r_count <= '0;
    else if (user_valid) r_count <= r_count + 32'd1;
  end

  assign w_count = r_count;
`else
  assign w_count = '0;
`endif

  assign opb.Sl_DBus    = r_dbus;
  assign opb.Sl_xferAck = r_ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  // Bus inputs the block deliberately ignores.
  assign w_unused = ^{opb.OPB_BE, opb.OPB_seqAddr, opb.OPB_DBus, (|C_FAMILY)};
endmodule

// File: doc/opb_register_simulink2ppc.md
OPB_REGISTER_SIMULINK2PPC -- requirements
Module: opb_register_simulink2ppc

Interface
REQ-001 Parameter C_BASEADDR, default 32'h01110000, base address of the register window.
REQ-002 Parameter C_HIGHADDR, default 32'h011100FF, top address of the register window.
REQ-003 Parameter C_OPB_AWIDTH, default 32, OPB address width.
REQ-004 Parameter C_OPB_DWIDTH, default 32, OPB data width.
REQ-005 Parameter C_FAMILY, default "virtex6", target family, no functional effect.
REQ-006 Ports SHALL be as follows:
- OPB_Clk  in  1  sole clock; every flop is on its rising edge.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables, ignored.
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
- user_data_in  in  [31:0]  fabric data word.
- user_valid  in  1  one-cycle capture strobe for user_data_in.

Function
REQ-007 The register map, as byte offsets from C_BASEADDR, SHALL be:
- 0x0 DATA (read-only).
- 0x4 STATUS: bit 31 NEW (read-only), bit 30 OVF (write-1-to-clear), other bits read 0.
- 0x8 COUNT (read; any write clears it).
- All other in-window offsets read 0, writes ignored, still acknowledged.
REQ-008 A hit SHALL be OPB_select=1 with C_BASEADDR <= OPB_ABus <= C_HIGHADDR; OPB_select=1 with an out-of-window address SHALL produce no response.
REQ-009 Transfer FSM, states IDLE and ACK:
- IDLE -> ACK on a hit.
- ACK -> IDLE unconditionally.
- Sl_xferAck=1 only in ACK, giving exactly one acknowledge, 1 cycle after the hit is sampled.
- OPB_select still high in the cycle after ACK is a new transfer.
REQ-010 Read data SHALL be registered at the hit cycle and driven on Sl_DBus during ACK only; Sl_DBus SHALL be 0 at all other times.
REQ-011 user_valid=1 SHALL load user_data_in into DATA and set NEW on the next edge.
REQ-012 user_valid=1 while NEW=1 SHALL set OVF, unless that same cycle is the ACK of a DATA read.
REQ-013 The ACK cycle of a DATA read SHALL clear NEW. If user_valid coincides, the capture wins: NEW stays 1, DATA takes the new word, OVF is unchanged.
REQ-014 The ACK cycle of a write to STATUS with OPB_DBus[30]=1 SHALL clear OVF. If the same cycle would also set OVF, the set wins.
REQ-015 Each user_valid pulse SHALL increment COUNT by 1, modulo 2^32 (0xFFFFFFFF -> 0).
REQ-016 A COUNT write in the same cycle as user_valid SHALL leave COUNT = 0.
REQ-017 A write to DATA SHALL be acknowledged with no effect.

Reset
REQ-018 While OPB_Rst_n=0, all of the following SHALL be 0, asynchronously: FSM=IDLE, DATA, NEW, OVF, COUNT, Sl_DBus, Sl_xferAck.
REQ-019 Reset asserted during ACK SHALL abort the transfer with no acknowledge issued.
REQ-020 The first hit SHALL be accepted on the first rising edge after OPB_Rst_n deasserts.

Configuration
REQ-021 With macro SIMULINK2PPC_COUNT_EN defined, COUNT SHALL be implemented per REQ-015 and REQ-016.
REQ-022 Without SIMULINK2PPC_COUNT_EN, there SHALL be no COUNT flops; offset 0x8 reads 0, and writes to it are acknowledged with no effect.

Verification
REQ-023 Pulse user_valid with 0xDEADBEEF, then read 0x0 -> Sl_DBus=0xDEADBEEF with Sl_xferAck for exactly one cycle, 1 cycle after select; a STATUS read then returns 0x00000000.
REQ-024 Two user_valid pulses (0x1, then 0x2) with no read in between -> STATUS=0x00000003 and DATA=0x2; write 0x00000002 to 0x4 -> STATUS=0x00000001.
REQ-025 user_valid with 0x55 in the ACK cycle of a DATA read -> the read returns the old word, then DATA=0x55, NEW=1, OVF=0.
REQ-026 With SIMULINK2PPC_COUNT_EN, COUNT preloaded to 0xFFFFFFFF by 0xFFFFFFFF pulses (or forced), plus one pulse -> COUNT=0; write to 0x8 -> COUNT=0; without the macro, 0x8 reads 0.
REQ-027 Assert OPB_Rst_n=0 mid-ACK -> Sl_xferAck and Sl_DBus go to 0 immediately; a STATUS read after release returns 0.
REQ-028 OPB_select with address 0x01110100 -> no Sl_xferAck for 16 cycles; a read of 0x0111000C -> 0x00000000, acknowledged.
